// File: rtl/pe_stream_wrap.sv
// pe_stream_wrap: registered, FIFO-buffered stream wrapper around an HLS
// processing element (PE). Each upstream channel passes through a one-stage
// input register into a first-word-fall-through FIFO that feeds the PE's
// AXI-Stream input. Each PE output stream lands in its own FWFT FIFO that
// drives the downstream Q/Q_VALID port. All channels are independent.
//
// Optional feature: define PE_STREAM_WRAP_CNT_EN to add the Q_CNT port,
// a free-running 32-bit count of words delivered on each output channel.

// ---------------------------------------------------------------------------
// First-word-fall-through FIFO. The head word is presented from a register
// loaded with the word at the post-pop read address, so the array can map to
// block RAM with a registered read port. A write landing on that same address
// is forwarded into the head register. Because the forward happens on the
// write edge, an empty FIFO never bypasses: a pushed word appears only once
// the count has become non-zero.
// ---------------------------------------------------------------------------
module pe_stream_fifo #(
  parameter int DATA_W     = 64,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                CLK,
  input  logic                SYS_RST_N,
  input  logic                flush,
  input  logic                push,
  input  logic [DATA_W-1:0]   din,
  input  logic                pop,
  output logic [DATA_W-1:0]   dout,
  output logic [DEPTH_LOG2:0] count,
  output logic                full,
  output logic                empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_addr_next;
  logic [DEPTH_LOG2:0]   count_reg;
  logic [DATA_W-1:0]     dout_reg;
  logic                  wr_en;
  logic                  rd_en;

  assign full  = (count_reg == FULL_LVL);
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign dout  = dout_reg;

  // A flush discards any push or pop on the same edge. A push into a full
  // FIFO is only taken when a pop frees the slot on that same edge.
  assign rd_en        = pop & ~empty & ~flush;
  assign wr_en        = push & (~full | rd_en) & ~flush;
  assign rd_addr_next = rd_en ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

  // Pointers and occupancy; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_addr_next;
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage array write port; contents need no reset.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr_reg] <= din;
  end

  // Registered head word: read at the address that will be the head after
  // this edge, forwarding a write that lands on that very slot.
  always_ff @(posedge CLK) begin
    if (wr_en && (wr_ptr_reg == rd_addr_next)) dout_reg <= din;
    else                                       dout_reg <= mem[rd_addr_next];
  end
endmodule

// ---------------------------------------------------------------------------
// Top level wrapper.
// ---------------------------------------------------------------------------
module pe_stream_wrap #(
  parameter int N_IN         = 2,
  parameter int N_OUT        = 2,
  parameter int DATA_W       = 64,
  parameter int DEPTH_LOG2   = 9,
  parameter int AFULL_MARGIN = 8
) (
  input  logic                    CLK,
  input  logic                    SYS_RST_N,
  input  logic                    PE_RST,
  // upstream side
  input  logic [N_IN*DATA_W-1:0]  D,
  input  logic [N_IN-1:0]         D_VALID,
  output logic [N_IN-1:0]         D_BP,
  // downstream side
  output logic [N_OUT*DATA_W-1:0] Q,
  output logic [N_OUT-1:0]        Q_VALID,
  input  logic [N_OUT-1:0]        Q_BP,
  // AXI-Stream into the PE
  output logic [N_IN*DATA_W-1:0]  PE_IN_TDATA,
  output logic [N_IN-1:0]         PE_IN_TVALID,
  input  logic [N_IN-1:0]         PE_IN_TREADY,
  // AXI-Stream out of the PE
  input  logic [N_OUT*DATA_W-1:0] PE_OUT_TDATA,
  input  logic [N_OUT-1:0]        PE_OUT_TVALID,
  output logic [N_OUT-1:0]        PE_OUT_TREADY,
`ifdef PE_STREAM_WRAP_CNT_EN
  output logic [N_OUT*32-1:0]     Q_CNT,
`endif
  output logic [N_IN-1:0]         OVF
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  // Occupancy at and above which the producer is asked to stop.
  localparam logic [DEPTH_LOG2:0] AFULL_LVL = (DEPTH_LOG2+1)'(DEPTH - AFULL_MARGIN);

  genvar gi;

  // ----------------------------- input channels ----------------------------
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_in
      logic [DATA_W-1:0]     d_reg;
      logic                  d_valid_reg;
      logic                  ovf_reg;
      logic [DEPTH_LOG2:0]   count;
      logic                  full;
      logic                  empty;
      logic                  pop;
      logic [DATA_W-1:0]     head;

      assign pop = ~empty & PE_IN_TREADY[gi];

      // Input data stage; the word itself needs no reset.
      always_ff @(posedge CLK) begin
        d_reg <= D[gi*DATA_W +: DATA_W];
      end

      // Input valid stage and sticky overflow flag (word dropped on a full
      // FIFO with no pop to make room).
      always_ff @(posedge CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
          d_valid_reg <= 1'b0;
          ovf_reg     <= 1'b0;
        end else if (PE_RST) begin
          d_valid_reg <= 1'b0;
          ovf_reg     <= 1'b0;
        end else begin
          d_valid_reg <= D_VALID[gi];
          if (d_valid_reg && full && !pop) ovf_reg <= 1'b1;
        end
      end

      pe_stream_fifo #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
      ) u_fifo (
        .CLK       (CLK),
        .SYS_RST_N (SYS_RST_N),
        .flush     (PE_RST),
        .push      (d_valid_reg),
        .din       (d_reg),
        .pop       (pop),
        .dout      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
      );

      assign PE_IN_TDATA[gi*DATA_W +: DATA_W] = head;
      assign PE_IN_TVALID[gi]                 = ~empty;
      assign D_BP[gi]                         = (count >= AFULL_LVL);
      assign OVF[gi]                          = ovf_reg;
    end
  endgenerate

  // ----------------------------- output channels ---------------------------
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_out
      logic [DEPTH_LOG2:0]   count;
      logic                  full;
      logic                  empty;
      logic                  tready;
      logic                  push;
      logic                  deliver;
      logic [DATA_W-1:0]     head;

      // The PE is throttled with the same margin as upstream so an HLS core
      // that reacts late to TREADY still has room to land its last words.
      assign tready  = ~full & (count < AFULL_LVL);
      assign push    = PE_OUT_TVALID[gi] & tready;
      assign deliver = ~empty & ~Q_BP[gi];

      pe_stream_fifo #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
      ) u_fifo (
        .CLK       (CLK),
        .SYS_RST_N (SYS_RST_N),
        .flush     (PE_RST),
        .push      (push),
        .din       (PE_OUT_TDATA[gi*DATA_W +: DATA_W]),
        .pop       (deliver),
        .dout      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
      );

      assign Q[gi*DATA_W +: DATA_W] = head;
      assign Q_VALID[gi]            = deliver;
      assign PE_OUT_TREADY[gi]      = tready;

`ifdef PE_STREAM_WRAP_CNT_EN
      logic [31:0] q_cnt_reg;

      // Words delivered downstream; wraps from all-ones back to zero.
      always_ff @(posedge CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N)   q_cnt_reg <= '0;
        else if (PE_RST)  q_cnt_reg <= '0;
        else if (deliver) q_cnt_reg <= q_cnt_reg + 32'd1;
      end

      assign Q_CNT[gi*32 +: 32] = q_cnt_reg;
`else
      // Delivery counting is compiled out in this build.
`endif
    end
  endgenerate
endmodule

// File: tb/tb_pe_stream_wrap.sv
// Directed self-checking bench for pe_stream_wrap, built with a 16-deep FIFO
// and a margin of 3 so the full/almost-full boundaries are cheap to reach.
module tb_pe_stream_wrap;
  localparam int NI = 2;
  localparam int NO = 2;
  localparam int DW = 64;
  localparam int DL = 4;
  localparam int AM = 3;

  logic             CLK = 1'b0;
  logic             SYS_RST_N;
  logic             PE_RST;
  logic [NI*DW-1:0] d;
  logic [NI-1:0]    d_valid;
  logic [NI-1:0]    d_bp;
  logic [NO*DW-1:0] q;
  logic [NO-1:0]    q_valid;
  logic [NO-1:0]    q_bp;
  logic [NI*DW-1:0] pe_in_tdata;
  logic [NI-1:0]    pe_in_tvalid;
  logic [NI-1:0]    pe_in_tready;
  logic [NO*DW-1:0] pe_out_tdata;
  logic [NO-1:0]    pe_out_tvalid;
  logic [NO-1:0]    pe_out_tready;
  logic [NI-1:0]    ovf;
`ifdef PE_STREAM_WRAP_CNT_EN
  logic [NO*32-1:0] q_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pe_stream_wrap #(
    .N_IN(NI), .N_OUT(NO), .DATA_W(DW), .DEPTH_LOG2(DL), .AFULL_MARGIN(AM)
  ) dut (
    .CLK(CLK), .SYS_RST_N(SYS_RST_N), .PE_RST(PE_RST),
    .D(d), .D_VALID(d_valid), .D_BP(d_bp),
    .Q(q), .Q_VALID(q_valid), .Q_BP(q_bp),
    .PE_IN_TDATA(pe_in_tdata), .PE_IN_TVALID(pe_in_tvalid), .PE_IN_TREADY(pe_in_tready),
    .PE_OUT_TDATA(pe_out_tdata), .PE_OUT_TVALID(pe_out_tvalid), .PE_OUT_TREADY(pe_out_tready),
`ifdef PE_STREAM_WRAP_CNT_EN
    .Q_CNT(q_cnt),
`endif
    .OVF(ovf)
  );

  always #5 CLK = ~CLK;

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++; if (d_bp !== 2'b00) begin errors++; $display("FAIL rst_d_bp got %b exp 00", d_bp); end
    checks++; if (pe_in_tvalid !== 2'b00) begin errors++; $display("FAIL rst_in_tvalid got %b exp 00", pe_in_tvalid); end
    checks++; if (q_valid !== 2'b00) begin errors++; $display("FAIL rst_q_valid got %b exp 00", q_valid); end
    checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL rst_ovf got %b exp 00", ovf); end
    checks++; if (pe_out_tready !== 2'b11) begin errors++; $display("FAIL rst_out_tready got %b exp 11", pe_out_tready); end
    SYS_RST_N = 1'b1;
    tick();
    $display("reset: checks=%0d errors=%0d", checks, errors);
  endtask

  // Four words on ch0 with the PE always ready: two-cycle latency, in order.
  task automatic test_in_latency();
    logic exp_v;
    pe_in_tready = 2'b01;
    tick();
    d[0 +: DW] = 64'h1; d_valid[0] = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      exp_v = (c >= 2) && (c <= 5);
      checks++; if (pe_in_tvalid[0] !== exp_v) begin errors++; $display("FAIL lat_valid cyc=%0d got %b exp %b", c, pe_in_tvalid[0], exp_v); end
      if (exp_v) begin
        checks++; if (pe_in_tdata[0 +: DW] !== 64'(c - 1)) begin errors++; $display("FAIL lat_data cyc=%0d got %h exp %h", c, pe_in_tdata[0 +: DW], 64'(c - 1)); end
      end
      checks++; if (pe_in_tvalid[1] !== 1'b0) begin errors++; $display("FAIL lat_ch1_idle cyc=%0d got %b exp 0", c, pe_in_tvalid[1]); end
      if (c < 4) d[0 +: DW] = 64'(c + 1);
      else       d_valid[0] = 1'b0;
    end
    $display("in_latency: checks=%0d errors=%0d", checks, errors);
  endtask

  // PE stalled, producer honors D_BP: BP rises at count 13, 14 words land.
  task automatic test_in_backpressure();
    int first_bp = 0;
    int sent = 0;
    int idx = 0;
    pe_in_tready = 2'b00;
    tick();
    d[0 +: DW] = 64'h101; d_valid[0] = 1'b1;
    for (int t = 1; t <= 24; t++) begin
      tick();
      if (d_valid[0]) sent++;
      if (d_bp[0] && first_bp == 0) first_bp = t;
      if (d_bp[0]) d_valid[0] = 1'b0;
      else begin d_valid[0] = 1'b1; d[0 +: DW] = 64'h100 + 64'(sent + 1); end
    end
    d_valid[0] = 1'b0;
    checks++; if (first_bp !== 14) begin errors++; $display("FAIL bp_first_edge got %0d exp 14", first_bp); end
    checks++; if (sent !== 14) begin errors++; $display("FAIL bp_words_sent got %0d exp 14", sent); end
    checks++; if (ovf[0] !== 1'b0) begin errors++; $display("FAIL bp_no_ovf got %b exp 0", ovf[0]); end
    checks++; if (d_bp[0] !== 1'b1) begin errors++; $display("FAIL bp_held got %b exp 1", d_bp[0]); end
    pe_in_tready[0] = 1'b1;
    for (int t = 0; t < 24; t++) begin
      if (pe_in_tvalid[0]) begin
        checks++; if (pe_in_tdata[0 +: DW] !== 64'h101 + 64'(idx)) begin errors++; $display("FAIL bp_drain_data idx=%0d got %h exp %h", idx, pe_in_tdata[0 +: DW], 64'h101 + 64'(idx)); end
        idx++;
      end
      tick();
    end
    checks++; if (idx !== 14) begin errors++; $display("FAIL bp_drain_count got %0d exp 14", idx); end
    checks++; if (d_bp[0] !== 1'b0) begin errors++; $display("FAIL bp_released got %b exp 0", d_bp[0]); end
    pe_in_tready[0] = 1'b0;
    $display("in_backpressure: checks=%0d errors=%0d", checks, errors);
  endtask

  // Ignore D_BP: 20 words into 16 slots sets OVF; push+pop at full keeps 16.
  task automatic test_overflow();
    int idx = 0;
    logic [DW-1:0] exp_w;
    pe_in_tready = 2'b00;
    tick();
    d[0 +: DW] = 64'h201; d_valid[0] = 1'b1;
    for (int t = 1; t <= 22; t++) begin
      tick();
      if (t == 17) begin
        checks++; if (ovf[0] !== 1'b0) begin errors++; $display("FAIL ovf_at_full got %b exp 0", ovf[0]); end
      end
      if (t == 18) begin
        checks++; if (ovf[0] !== 1'b1) begin errors++; $display("FAIL ovf_first_drop got %b exp 1", ovf[0]); end
      end
      if (t < 20) d[0 +: DW] = 64'h201 + 64'(t);
      else        d_valid[0] = 1'b0;
    end
    // One more word arrives exactly as the PE takes one.
    d[0 +: DW] = 64'h2FF; d_valid[0] = 1'b1;
    tick();
    d_valid[0] = 1'b0; pe_in_tready[0] = 1'b1;
    tick();
    pe_in_tready[0] = 1'b0;
    checks++; if (d_bp[0] !== 1'b1) begin errors++; $display("FAIL ovf_bp_full got %b exp 1", d_bp[0]); end
    checks++; if (ovf[0] !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf[0]); end
    pe_in_tready[0] = 1'b1;
    for (int t = 0; t < 24; t++) begin
      if (pe_in_tvalid[0]) begin
        exp_w = (idx < 15) ? 64'h202 + 64'(idx) : 64'h2FF;
        checks++; if (pe_in_tdata[0 +: DW] !== exp_w) begin errors++; $display("FAIL ovf_drain_data idx=%0d got %h exp %h", idx, pe_in_tdata[0 +: DW], exp_w); end
        idx++;
      end
      tick();
    end
    pe_in_tready[0] = 1'b0;
    checks++; if (idx !== 16) begin errors++; $display("FAIL ovf_drain_count got %0d exp 16", idx); end
    $display("overflow: checks=%0d errors=%0d", checks, errors);
  endtask

  // Q_BP holds ch1 output; release delivers 0xA, 0xB back to back.
  task automatic test_out_hold();
    q_bp = 2'b10;
    tick();
    checks++; if (pe_out_tready[1] !== 1'b1) begin errors++; $display("FAIL hold_tready got %b exp 1", pe_out_tready[1]); end
    pe_out_tdata[DW +: DW] = 64'hA; pe_out_tvalid[1] = 1'b1;
    tick();
    pe_out_tdata[DW +: DW] = 64'hB;
    tick();
    pe_out_tvalid[1] = 1'b0;
    for (int t = 0; t < 3; t++) begin
      checks++; if (q_valid !== 2'b00) begin errors++; $display("FAIL hold_q_valid t=%0d got %b exp 00", t, q_valid); end
      tick();
    end
    q_bp[1] = 1'b0;
    #1;
    checks++; if (q_valid !== 2'b10) begin errors++; $display("FAIL rel_valid_a got %b exp 10", q_valid); end
    checks++; if (q[DW +: DW] !== 64'hA) begin errors++; $display("FAIL rel_data_a got %h exp a", q[DW +: DW]); end
    tick();
    checks++; if (q_valid[1] !== 1'b1) begin errors++; $display("FAIL rel_valid_b got %b exp 1", q_valid[1]); end
    checks++; if (q[DW +: DW] !== 64'hB) begin errors++; $display("FAIL rel_data_b got %h exp b", q[DW +: DW]); end
    tick();
    checks++; if (q_valid[1] !== 1'b0) begin errors++; $display("FAIL rel_empty got %b exp 0", q_valid[1]); end
    $display("out_hold: checks=%0d errors=%0d", checks, errors);
  endtask

  // Output FIFO throttles the PE at 13 entries, then drains in order.
  task automatic test_out_afull();
    int pushed = 0;
    int idx = 0;
    q_bp[0] = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (pe_out_tready[0]) begin
        pe_out_tdata[0 +: DW] = 64'h300 + 64'(pushed);
        pe_out_tvalid[0] = 1'b1;
        pushed++;
      end else pe_out_tvalid[0] = 1'b0;
      tick();
    end
    pe_out_tvalid[0] = 1'b0;
    checks++; if (pushed !== 13) begin errors++; $display("FAIL afull_pushed got %0d exp 13", pushed); end
    checks++; if (pe_out_tready[0] !== 1'b0) begin errors++; $display("FAIL afull_tready got %b exp 0", pe_out_tready[0]); end
    q_bp[0] = 1'b0;
    #1;
    for (int t = 0; t < 20; t++) begin
      if (q_valid[0]) begin
        checks++; if (q[0 +: DW] !== 64'h300 + 64'(idx)) begin errors++; $display("FAIL afull_data idx=%0d got %h exp %h", idx, q[0 +: DW], 64'h300 + 64'(idx)); end
        idx++;
      end
      tick();
    end
    checks++; if (idx !== 13) begin errors++; $display("FAIL afull_drain_count got %0d exp 13", idx); end
    $display("out_afull: checks=%0d errors=%0d", checks, errors);
  endtask

  // PE_RST mid-stream with 5 words queued in each direction.
  task automatic test_flush();
    pe_in_tready = 2'b00; q_bp = 2'b11;
    for (int k = 0; k < 5; k++) begin
      d[0 +: DW] = 64'h400 + 64'(k); d_valid[0] = 1'b1;
      pe_out_tdata[DW +: DW] = 64'h500 + 64'(k); pe_out_tvalid[1] = 1'b1;
      tick();
    end
    d[0 +: DW] = 64'h405; pe_out_tvalid[1] = 1'b0;
    tick();
    checks++; if (pe_in_tvalid[0] !== 1'b1) begin errors++; $display("FAIL pre_flush_valid got %b exp 1", pe_in_tvalid[0]); end
    checks++; if (pe_in_tdata[0 +: DW] !== 64'h400) begin errors++; $display("FAIL pre_flush_head got %h exp 400", pe_in_tdata[0 +: DW]); end
    checks++; if (ovf[0] !== 1'b1) begin errors++; $display("FAIL pre_flush_ovf got %b exp 1", ovf[0]); end
`ifdef PE_STREAM_WRAP_CNT_EN
    checks++; if (q_cnt !== {32'd2, 32'd13}) begin errors++; $display("FAIL pre_flush_cnt got %h exp %h", q_cnt, {32'd2, 32'd13}); end
`endif
    d[0 +: DW] = 64'h406; PE_RST = 1'b1;
    tick();
    PE_RST = 1'b0; d_valid[0] = 1'b0;
    checks++; if (pe_in_tvalid !== 2'b00) begin errors++; $display("FAIL flush_in_valid got %b exp 00", pe_in_tvalid); end
    checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL flush_ovf got %b exp 00", ovf); end
    checks++; if (d_bp !== 2'b00) begin errors++; $display("FAIL flush_d_bp got %b exp 00", d_bp); end
    checks++; if (pe_out_tready !== 2'b11) begin errors++; $display("FAIL flush_tready got %b exp 11", pe_out_tready); end
`ifdef PE_STREAM_WRAP_CNT_EN
    checks++; if (q_cnt !== 64'd0) begin errors++; $display("FAIL flush_cnt got %h exp 0", q_cnt); end
`endif
    q_bp = 2'b00;
    #1;
    checks++; if (q_valid !== 2'b00) begin errors++; $display("FAIL flush_q_valid got %b exp 00", q_valid); end
    tick();
    checks++; if (pe_in_tvalid !== 2'b00) begin errors++; $display("FAIL flush_inflight got %b exp 00", pe_in_tvalid); end
    $display("flush: checks=%0d errors=%0d", checks, errors);
  endtask

  // SYS_RST_N dropped between edges clears state without a clock.
  task automatic test_async_reset();
    pe_in_tready = 2'b00; q_bp = 2'b11;
    d[DW +: DW] = 64'h600; d_valid[1] = 1'b1;
    pe_out_tdata[0 +: DW] = 64'h700; pe_out_tvalid[0] = 1'b1;
    tick();
    d_valid[1] = 1'b0; pe_out_tvalid[0] = 1'b0;
    repeat (2) tick();
    checks++; if (pe_in_tvalid[1] !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %b exp 1", pe_in_tvalid[1]); end
    #2;
    SYS_RST_N = 1'b0; q_bp = 2'b00;
    #1;
    checks++; if (pe_in_tvalid !== 2'b00) begin errors++; $display("FAIL arst_in_valid got %b exp 00", pe_in_tvalid); end
    checks++; if (q_valid !== 2'b00) begin errors++; $display("FAIL arst_q_valid got %b exp 00", q_valid); end
    checks++; if (pe_out_tready !== 2'b11) begin errors++; $display("FAIL arst_tready got %b exp 11", pe_out_tready); end
    checks++; if (d_bp !== 2'b00 || ovf !== 2'b00) begin errors++; $display("FAIL arst_bp_ovf got %b/%b exp 00/00", d_bp, ovf); end
    tick();
    SYS_RST_N = 1'b1;
    repeat (2) tick();
    checks++; if (pe_in_tvalid !== 2'b00 || q_valid !== 2'b00) begin errors++; $display("FAIL arst_after got %b/%b exp 00/00", pe_in_tvalid, q_valid); end
    $display("async_reset: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    SYS_RST_N = 1'b0; PE_RST = 1'b0;
    d = '0; d_valid = '0; q_bp = '0; pe_in_tready = '0;
    pe_out_tdata = '0; pe_out_tvalid = '0;
    test_reset();
    test_in_latency();
    test_in_backpressure();
    test_overflow();
    test_out_hold();
    test_out_afull();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pe_stream_wrap.md
PE_STREAM_WRAP -- requirements
Module: pe_stream_wrap

Interface
REQ-001 SHALL have parameter N_IN, default 2, number of input stream channels (1..8).
REQ-002 SHALL have parameter N_OUT, default 2, number of output stream channels (1..8).
REQ-003 SHALL have parameter DATA_W, default 64, stream word width in bits.
REQ-004 SHALL have parameter DEPTH_LOG2, default 9, log2 of each FIFO depth (DEPTH = 2^DEPTH_LOG2).
REQ-005 SHALL have parameter AFULL_MARGIN, default 8, free-entry threshold for backpressure (at least 3).
REQ-006 SHALL have port CLK  input  1  sole clock, all logic rising-edge.
REQ-007 SHALL have port SYS_RST_N  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-008 SHALL have port PE_RST  input  1  synchronous active-high flush of all FIFOs and flags.
REQ-009 SHALL have ports D  input  N_IN*DATA_W, D_VALID  input  N_IN, D_BP  output  N_IN  upstream inputs, channel i at bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have ports Q  output  N_OUT*DATA_W, Q_VALID  output  N_OUT, Q_BP  input  N_OUT  downstream outputs.
REQ-011 SHALL have ports PE_IN_TDATA  output  N_IN*DATA_W, PE_IN_TVALID  output  N_IN, PE_IN_TREADY  input  N_IN  AXI-Stream to the HLS PE.
REQ-012 SHALL have ports PE_OUT_TDATA  input  N_OUT*DATA_W, PE_OUT_TVALID  input  N_OUT, PE_OUT_TREADY  output  N_OUT  AXI-Stream from the HLS PE.
REQ-013 SHALL have port OVF  output  N_IN  sticky per-channel input overflow flag.

Function
REQ-014 SHALL register D/D_VALID per channel (one stage) and push the registered word into input FIFO i on the following edge; a word sampled at edge k is visible on PE_IN_TDATA/PE_IN_TVALID after edge k+1.
REQ-015 SHALL implement each FIFO as first-word-fall-through: head word on the data output and valid high whenever count > 0, no bypass when empty.
REQ-016 SHALL pop input FIFO i on an edge where PE_IN_TVALID[i] and PE_IN_TREADY[i] are both high.
REQ-017 SHALL drive D_BP[i] high combinationally from registered count when count >= DEPTH - AFULL_MARGIN.
REQ-018 SHALL accept a push to a full FIFO only if a pop occurs on the same edge (count unchanged); otherwise drop the word and set OVF[i], which stays set until reset or PE_RST.
REQ-019 SHALL push output FIFO j when PE_OUT_TVALID[j] and PE_OUT_TREADY[j]; PE_OUT_TREADY[j] = ~full & (count < DEPTH - AFULL_MARGIN).
REQ-020 SHALL drive Q_VALID[j] = ~empty & ~Q_BP[j] and pop output FIFO j on every edge Q_VALID[j] is high.
REQ-021 SHALL wrap FIFO read/write pointers modulo DEPTH with a DEPTH_LOG2+1-bit count; full at count = DEPTH, empty at count = 0.
REQ-022 SHALL, on PE_RST high at an edge, zero all counts/pointers, input register valids and OVF; pushes/pops on that edge are discarded.
REQ-023 SHALL keep channels fully independent; no cross-channel stalls.

Reset
REQ-024 SHALL, while SYS_RST_N is low, asynchronously clear all FIFO counts, pointers, input valid registers, OVF and counters.
REQ-025 SHALL hold D_BP, PE_IN_TVALID, Q_VALID, OVF low and PE_OUT_TREADY high during reset; data outputs are don't-care.
REQ-026 SHALL not require FIFO storage arrays to be reset.

Configuration
REQ-027 SHALL, with PE_STREAM_WRAP_CNT_EN defined, add output Q_CNT (N_OUT*32) giving per-output-channel words delivered (Q_VALID edges), wrapping 2^32-1 to 0, cleared by reset and PE_RST.
REQ-028 SHALL, without PE_STREAM_WRAP_CNT_EN, omit Q_CNT and all counter logic.

Verification
REQ-029 SHALL cover: N_IN=2, 4 words 0x1..0x4 on ch0, PE_IN_TREADY=1 -> PE_IN_TVALID[0] rises 2 cycles after first D_VALID, data 0x1..0x4 in order.
REQ-030 SHALL cover: DEPTH_LOG2=4, MARGIN=3, PE_IN_TREADY=0, continuous D_VALID honoring D_BP -> D_BP high at count 13, no OVF, count never exceeds 16.
REQ-031 SHALL cover: ignore D_BP, push 20 words into depth-16 FIFO -> OVF[0]=1, exactly 16 words later delivered; push+pop at full keeps count 16.
REQ-032 SHALL cover: Q_BP[1]=1 with output FIFO non-empty -> Q_VALID[1]=0, no pop; release -> words 0xA,0xB delivered back-to-back.
REQ-033 SHALL cover: PE_RST mid-stream with 5 words queued -> next cycle all valids 0, OVF 0, Q_CNT 0 (when enabled); SYS_RST_N low asynchronously clears same.
